// File: rtl/qsfp_link_pkg.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | qsfp_link_pkg: shared types and constants for the QSFP0 link sequencer.    |
// | Revision: 1.0                                                              |
// +----------------------------------------------------------------------------+
package qsfp_link_pkg;

    localparam int STATS_WIDTH = 16;

    typedef enum logic [2:0] {
        ST_ABSENT    = 3'd0,
        ST_MOD_RST   = 3'd1,
        ST_MOD_INIT  = 3'd2,
        ST_GT_RST    = 3'd3,
        ST_WAIT_LOCK = 3'd4,
        ST_RX_RST    = 3'd5,
        ST_UP        = 3'd6
    } link_state_t;

endpackage : qsfp_link_pkg
`default_nettype wire

// File: rtl/qsfp_link_sequencer_sync_bit.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | sync_bit: two-flop synchronizer with a configurable reset value.           |
// | Revision: 1.0                                                              |
// +----------------------------------------------------------------------------+
module sync_bit #(
    parameter logic RESET_VAL = 1'b0
) (
    input  logic clk,
    input  logic rst,
    input  logic i_d,
    output logic o_q
);

    logic meta_q, meta_d;
    logic sync_q, sync_d;

    always_comb begin
        meta_d = i_d;
        sync_d = meta_q;
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            meta_q <= RESET_VAL;
            sync_q <= RESET_VAL;
        end else begin
            meta_q <= meta_d;
            sync_q <= sync_d;
        end
    end

    assign o_q = sync_q;

endmodule : sync_bit
`default_nettype wire

// File: rtl/qsfp_link_sequencer.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | qsfp_link_sequencer: QSFP0 presence/reset, GT reset and block-lock        |
// | bring-up controller. Optional LINK_STATS_EN enables the stats counters.    |
// | Revision: 1.0                                                              |
// +----------------------------------------------------------------------------+
module qsfp_link_sequencer
    import qsfp_link_pkg::*;
#(
    parameter int TIMER_WIDTH         = 24,
    parameter int MOD_RST_CYCLES      = 1250,
    parameter int MOD_INIT_CYCLES     = 250000,
    parameter int GT_RST_CYCLES       = 128,
    parameter int RX_RST_CYCLES       = 32,
    parameter int LOCK_STABLE_CYCLES  = 1024,
    parameter int LOCK_TIMEOUT_CYCLES = 12500000,
    parameter int MAX_RX_RETRIES      = 4
) (
    input  logic                   clk_125mhz_int,
    input  logic                   gt_tx_reset,
    input  logic                   qsfp_modprsl,
    input  logic                   gt_reset_rx_done,
    input  logic                   rx_block_lock,
    output logic                   qsfp_resetl,
    output logic                   qsfp_lpmode,
    output logic                   gt_reset_all,
    output logic                   gt_reset_rx_datapath,
    output logic                   link_up,
    output logic [2:0]             state_o,
    output logic [STATS_WIDTH-1:0] link_drop_count,
    output logic [STATS_WIDTH-1:0] retry_count
);

    localparam int C_RIDX_W = (MAX_RX_RETRIES < 1) ? 1 : $clog2(MAX_RX_RETRIES + 1);

    localparam logic [TIMER_WIDTH-1:0] C_MOD_RST_LOAD  = TIMER_WIDTH'(MOD_RST_CYCLES - 1);
    localparam logic [TIMER_WIDTH-1:0] C_MOD_INIT_LOAD = TIMER_WIDTH'(MOD_INIT_CYCLES - 1);
    localparam logic [TIMER_WIDTH-1:0] C_GT_RST_LOAD   = TIMER_WIDTH'(GT_RST_CYCLES - 1);
    localparam logic [TIMER_WIDTH-1:0] C_RX_RST_LOAD   = TIMER_WIDTH'(RX_RST_CYCLES - 1);
    localparam logic [TIMER_WIDTH-1:0] C_TIMEOUT_LOAD  = TIMER_WIDTH'(LOCK_TIMEOUT_CYCLES - 1);
    localparam logic [TIMER_WIDTH-1:0] C_STABLE_LAST   = TIMER_WIDTH'(LOCK_STABLE_CYCLES - 1);
    localparam logic [C_RIDX_W-1:0]    C_MAX_RETRIES   = C_RIDX_W'(MAX_RX_RETRIES);

    logic w_modprsl_sync;
    logic w_rx_done_sync;
    logic w_lock_sync;

    sync_bit #(.RESET_VAL(1'b1)) u_sync_modprsl (
        .clk (clk_125mhz_int),
        .rst (gt_tx_reset),
        .i_d (qsfp_modprsl),
        .o_q (w_modprsl_sync)
    );

    sync_bit #(.RESET_VAL(1'b0)) u_sync_rx_done (
        .clk (clk_125mhz_int),
        .rst (gt_tx_reset),
        .i_d (gt_reset_rx_done),
        .o_q (w_rx_done_sync)
    );

    sync_bit #(.RESET_VAL(1'b0)) u_sync_lock (
        .clk (clk_125mhz_int),
        .rst (gt_tx_reset),
        .i_d (rx_block_lock),
        .o_q (w_lock_sync)
    );

    link_state_t            state_q, state_d;
    logic [TIMER_WIDTH-1:0] timer_q, timer_d;
    logic [TIMER_WIDTH-1:0] stable_q, stable_d;
    logic [C_RIDX_W-1:0]    retry_idx_q, retry_idx_d;
    logic                   resetl_q, resetl_d;
    logic                   lpmode_q, lpmode_d;
    logic                   gt_reset_all_q, gt_reset_all_d;
    logic                   gt_reset_rx_q, gt_reset_rx_d;
    logic                   link_up_q, link_up_d;
    logic                   w_lock_done;
    logic                   w_retry_event;
    logic                   w_drop_event;

    always_comb begin
        state_d       = state_q;
        timer_d       = (timer_q != '0) ? timer_q - 1'b1 : timer_q;
        stable_d      = stable_q;
        retry_idx_d   = retry_idx_q;
        w_lock_done   = 1'b0;
        w_retry_event = 1'b0;
        w_drop_event  = 1'b0;

        unique case (state_q)
            ST_ABSENT: begin
                if (!w_modprsl_sync) begin
                    state_d = ST_MOD_RST;
                    timer_d = C_MOD_RST_LOAD;
                end
            end
            ST_MOD_RST: begin
                if (timer_q == '0) begin
                    state_d = ST_MOD_INIT;
                    timer_d = C_MOD_INIT_LOAD;
                end
            end
            ST_MOD_INIT: begin
                if (timer_q == '0) begin
                    state_d     = ST_GT_RST;
                    timer_d     = C_GT_RST_LOAD;
                    retry_idx_d = '0;
                end
            end
            ST_GT_RST: begin
                if (timer_q == '0) begin
                    state_d  = ST_WAIT_LOCK;
                    timer_d  = C_TIMEOUT_LOAD;
                    stable_d = '0;
                end
            end
            ST_WAIT_LOCK: begin
                // The timeout only runs once the GT reports its RX reset is done.
                if (!w_rx_done_sync) begin
                    timer_d = timer_q;
                end
                if (w_lock_sync) begin
                    if (stable_q == C_STABLE_LAST) begin
                        w_lock_done = 1'b1;
                        state_d     = ST_UP;
                        retry_idx_d = '0;
                    end else begin
                        stable_d = stable_q + 1'b1;
                    end
                end else begin
                    stable_d = '0;
                end
                if (!w_lock_done && timer_q == '0 && w_rx_done_sync) begin
                    if (retry_idx_q < C_MAX_RETRIES) begin
                        retry_idx_d   = retry_idx_q + 1'b1;
                        w_retry_event = 1'b1;
                        state_d       = ST_RX_RST;
                        timer_d       = C_RX_RST_LOAD;
                    end else begin
                        state_d = ST_GT_RST;
                        timer_d = C_GT_RST_LOAD;
                    end
                end
            end
            ST_RX_RST: begin
                if (timer_q == '0) begin
                    state_d  = ST_WAIT_LOCK;
                    timer_d  = C_TIMEOUT_LOAD;
                    stable_d = '0;
                end
            end
            ST_UP: begin
                if (!w_lock_sync) begin
                    state_d      = ST_WAIT_LOCK;
                    timer_d      = C_TIMEOUT_LOAD;
                    stable_d     = '0;
                    w_drop_event = 1'b1;
                end
            end
            default: begin
                state_d = ST_ABSENT;
            end
        endcase

        // Module removal wins over everything, including pending stat events.
        if (w_modprsl_sync) begin
            state_d       = ST_ABSENT;
            w_retry_event = 1'b0;
            w_drop_event  = 1'b0;
        end

        resetl_d       = !(state_d inside {ST_ABSENT, ST_MOD_RST});
        lpmode_d       = (state_d == ST_ABSENT);
        gt_reset_all_d = (state_d inside {ST_ABSENT, ST_MOD_RST, ST_MOD_INIT, ST_GT_RST});
        gt_reset_rx_d  = (state_d == ST_RX_RST);
        link_up_d      = (state_d == ST_UP);
    end

    always_ff @(posedge clk_125mhz_int or posedge gt_tx_reset) begin
        if (gt_tx_reset) begin
            state_q        <= ST_ABSENT;
            timer_q        <= '0;
            stable_q       <= '0;
            retry_idx_q    <= '0;
            resetl_q       <= 1'b0;
            lpmode_q       <= 1'b1;
            gt_reset_all_q <= 1'b1;
            gt_reset_rx_q  <= 1'b0;
            link_up_q      <= 1'b0;
        end else begin
            state_q        <= state_d;
            timer_q        <= timer_d;
            stable_q       <= stable_d;
            retry_idx_q    <= retry_idx_d;
            resetl_q       <= resetl_d;
            lpmode_q       <= lpmode_d;
            gt_reset_all_q <= gt_reset_all_d;
            gt_reset_rx_q  <= gt_reset_rx_d;
            link_up_q      <= link_up_d;
        end
    end

    assign qsfp_resetl          = resetl_q;
    assign qsfp_lpmode          = lpmode_q;
    assign gt_reset_all         = gt_reset_all_q;
    assign gt_reset_rx_datapath = gt_reset_rx_q;
    assign link_up              = link_up_q;
    assign state_o              = state_q;

`ifdef LINK_STATS_EN
    logic [STATS_WIDTH-1:0] drop_cnt_q, drop_cnt_d;
    logic [STATS_WIDTH-1:0] retry_cnt_q, retry_cnt_d;

    always_comb begin
        drop_cnt_d  = drop_cnt_q;
        retry_cnt_d = retry_cnt_q;
        if (w_drop_event && drop_cnt_q != '1) begin
            drop_cnt_d = drop_cnt_q + 1'b1;
        end
        if (w_retry_event && retry_cnt_q != '1) begin
            retry_cnt_d = retry_cnt_q + 1'b1;
        end
    end

    always_ff @(posedge clk_125mhz_int or posedge gt_tx_reset) begin
        if (gt_tx_reset) begin
            drop_cnt_q  <= '0;
            retry_cnt_q <= '0;
        end else begin
            drop_cnt_q  <= drop_cnt_d;
            retry_cnt_q <= retry_cnt_d;
        end
    end

    assign link_drop_count = drop_cnt_q;
    assign retry_count     = retry_cnt_q;
`else
    logic w_unused_stats;
    assign w_unused_stats  = w_drop_event ^ w_retry_event;
    assign link_drop_count = '0;
    assign retry_count     = '0;
`endif

endmodule : qsfp_link_sequencer
`default_nettype wire

// File: tb/tb_qsfp_link_sequencer.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | tb_qsfp_link_sequencer: event scoreboard bench for qsfp_link_sequencer.    |
// | Revision: 1.0                                                              |
// +----------------------------------------------------------------------------+
module tb_qsfp_link_sequencer;

    localparam int P_MOD_RST  = 10;
    localparam int P_MOD_INIT = 20;
    localparam int P_GT_RST   = 8;
    localparam int P_RX_RST   = 4;
    localparam int P_STABLE   = 16;
    localparam int P_TIMEOUT  = 50;
    localparam int P_RETRIES  = 2;
    // Sync pipeline: input driven at negedge of cycle c acts on the FSM at edge c+3.
    localparam int P_LAT      = 3;

`ifdef LINK_STATS_EN
    localparam bit STATS_ON = 1'b1;
`else
    localparam bit STATS_ON = 1'b0;
`endif

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        modprsl = 1'b1;
    logic        rx_done = 1'b0;
    logic        lock = 1'b0;
    logic        resetl, lpmode, gall, grx, up;
    logic [2:0]  state;
    logic [15:0] drops, retries;

    int cyc = 0;
    int checks = 0;
    int errors = 0;
    bit mon_en = 1'b0;
    int n_drops = 0;
    int n_retries = 0;

    typedef struct {
        int st;
        int at;
    } ev_t;
    ev_t exp_q[$];

    qsfp_link_sequencer #(
        .TIMER_WIDTH         (24),
        .MOD_RST_CYCLES      (P_MOD_RST),
        .MOD_INIT_CYCLES     (P_MOD_INIT),
        .GT_RST_CYCLES       (P_GT_RST),
        .RX_RST_CYCLES       (P_RX_RST),
        .LOCK_STABLE_CYCLES  (P_STABLE),
        .LOCK_TIMEOUT_CYCLES (P_TIMEOUT),
        .MAX_RX_RETRIES      (P_RETRIES)
    ) dut (
        .clk_125mhz_int       (clk),
        .gt_tx_reset          (rst),
        .qsfp_modprsl         (modprsl),
        .gt_reset_rx_done     (rx_done),
        .rx_block_lock        (lock),
        .qsfp_resetl          (resetl),
        .qsfp_lpmode          (lpmode),
        .gt_reset_all         (gall),
        .gt_reset_rx_datapath (grx),
        .link_up              (up),
        .state_o              (state),
        .link_drop_count      (drops),
        .retry_count          (retries)
    );

    initial forever #4 clk = ~clk;

    always @(posedge clk) cyc <= cyc + 1;

    // Pin levels each state must present: {resetl, lpmode, gt_reset_all, gt_reset_rx, link_up}.
    function automatic logic [4:0] pins_for(int st);
        logic rl, lp, ga, gr, lu;
        rl = !(st == 0 || st == 1);
        lp = (st == 0);
        ga = (st == 0 || st == 1 || st == 2 || st == 3);
        gr = (st == 5);
        lu = (st == 6);
        return {rl, lp, ga, gr, lu};
    endfunction

    task automatic push(int st, int at);
        ev_t e;
        e.st = st;
        e.at = at;
        exp_q.push_back(e);
    endtask

    task automatic chk(string name, int act, int expv);
        checks++;
        if (act != expv) begin
            errors++;
            $display("FAIL %s: got %0d expected %0d (cycle %0d)", name, act, expv, cyc);
        end
    endtask

    task automatic to_cyc(int c);
        while (cyc < c) @(negedge clk);
    endtask

    // Monitor: every state change must match the next predicted event.
    initial begin
        int   prev;
        ev_t  e;
        logic [4:0] act_pins;
        prev = 0;
        forever begin
            @(negedge clk);
            act_pins = {resetl, lpmode, gall, grx, up};
            if (mon_en && int'(state) != prev) begin
                checks++;
                if (exp_q.size() == 0) begin
                    errors++;
                    $display("FAIL unexpected_transition: state %0d at cycle %0d, none predicted",
                             state, cyc);
                end else begin
                    e = exp_q.pop_front();
                    if (int'(state) != e.st || cyc != e.at || act_pins != pins_for(e.st)) begin
                        errors++;
                        $display("FAIL transition: got state=%0d cyc=%0d pins=%b, expected state=%0d cyc=%0d pins=%b",
                                 state, cyc, act_pins, e.st, e.at, pins_for(e.st));
                    end
                end
            end
            prev = int'(state);
        end
    end

    initial begin
        int c, w, t1, n, g, up_at;

        // Reset state
        repeat (3) @(negedge clk);
        #1;
        chk("rst_state", state, 0);
        chk("rst_pins", {resetl, lpmode, gall, grx, up}, 5'b01100);
        chk("rst_drops", drops, 0);
        chk("rst_retries", retries, 0);
        @(negedge clk);
        rst = 1'b0;
        mon_en = 1'b1;

        // Module absent for 100 cycles: nothing may move
        repeat (100) @(negedge clk);
        #1;
        chk("absent_state", state, 0);
        chk("absent_pins", {resetl, lpmode, gall, grx, up}, 5'b01100);

        // Insertion and bring-up to WAIT_LOCK
        to_cyc(cyc + 1 + int'($urandom_range(0, 19)));
        rx_done = 1'b1;
        modprsl = 1'b0;
        c = cyc;
        push(1, c + P_LAT);
        push(2, c + P_LAT + P_MOD_RST);
        push(3, c + P_LAT + P_MOD_RST + P_MOD_INIT);
        w = c + P_LAT + P_MOD_RST + P_MOD_INIT + P_GT_RST;
        push(4, w);

        // Lock with a one-cycle glitch that restarts the stability count
        to_cyc(w + int'($urandom_range(0, 10)));
        lock = 1'b1;
        g = int'($urandom_range(3, 12));
        repeat (g) @(negedge clk);
        lock = 1'b0;
        @(negedge clk);
        lock = 1'b1;
        up_at = cyc + P_LAT - 1 + P_STABLE;
        push(6, up_at);
        to_cyc(up_at + int'($urandom_range(2, 15)));
        #1;
        chk("up_link", up, 1);
        chk("up_drops", drops, 0);

        // Lock loss in UP, then retries with an rx_done stall, then escalation
        to_cyc(cyc + 1);
        lock = 1'b0;
        c = cyc;
        n_drops++;
        w = c + P_LAT;
        push(4, w);
        to_cyc(w + 5);
        rx_done = 1'b0;
        n = int'($urandom_range(1, 10));
        repeat (n) @(negedge clk);
        rx_done = 1'b1;
        t1 = w + P_TIMEOUT + n;
        for (int i = 0; i < P_RETRIES; i++) begin
            push(5, t1);
            push(4, t1 + P_RX_RST);
            n_retries++;
            t1 = t1 + P_RX_RST + P_TIMEOUT;
        end
        push(3, t1);
        w = t1 + P_GT_RST;
        push(4, w);
        to_cyc(w + 5);
        #1;
        chk("drop_link", up, 0);
        chk("drop_count", drops, STATS_ON ? n_drops : 0);
        chk("retry_count", retries, STATS_ON ? n_retries : 0);

        // Removal during WAIT_LOCK
        to_cyc(cyc + 1);
        modprsl = 1'b1;
        c = cyc;
        push(0, c + P_LAT);
        to_cyc(c + P_LAT);
        #1;
        chk("remove_resetl", resetl, 0);
        chk("remove_counts_kept", drops + retries, STATS_ON ? (n_drops + n_retries) : 0);

        // Async reset in the middle of MOD_INIT
        to_cyc(cyc + 1);
        modprsl = 1'b0;
        c = cyc;
        push(1, c + P_LAT);
        push(2, c + P_LAT + P_MOD_RST);
        to_cyc(c + P_LAT + P_MOD_RST + int'($urandom_range(1, 15)));
        #2;
        rst = 1'b1;
        push(0, cyc + 1);
        n_drops = 0;
        n_retries = 0;
        #1;
        chk("arst_state", state, 0);
        chk("arst_pins", {resetl, lpmode, gall, grx, up}, 5'b01100);
        chk("arst_counts", drops + retries, 0);

        // Restart from ABSENT with lock already present
        lock = 1'b1;
        repeat (2) @(negedge clk);
        rst = 1'b0;
        c = cyc;
        push(1, c + P_LAT);
        push(2, c + P_LAT + P_MOD_RST);
        push(3, c + P_LAT + P_MOD_RST + P_MOD_INIT);
        w = c + P_LAT + P_MOD_RST + P_MOD_INIT + P_GT_RST;
        push(4, w);
        push(6, w + P_STABLE);
        to_cyc(w + P_STABLE + 3);
        #1;
        chk("reup_link", up, 1);

        // Removal from UP is not a link drop
        to_cyc(cyc + 1);
        modprsl = 1'b1;
        c = cyc;
        push(0, c + P_LAT);
        to_cyc(c + P_LAT + 1);
        #1;
        chk("remove_up_link", up, 0);
        chk("remove_up_drops", drops, 0);

        repeat (5) @(negedge clk);
        chk("events_pending", exp_q.size(), 0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule : tb_qsfp_link_sequencer
`default_nettype wire
